// File: rtl/rv_pkg.sv
// Shared definitions for the rv core: default datapath width, the hardwired-zero
// register index and the register-index width helper.
package rv_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_ZERO     = 0;

  function automatic int aw_of(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/rv_rf_wrsel.sv
// Write-port selector for one register index: reports whether any write port
// targets idx this cycle and, if several do, the data of the highest-index port.
module rv_rf_wrsel
  import rv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NWR  = 1,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]       idx,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_reg,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  // Ascending scan so the last matching (highest-index) port overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_reg[w*AW +: AW] == idx) && (idx != AW'(REG_ZERO))) begin
        hit  = 1'b1;
        data = wr_data[w*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/rv_rf_mp.sv
// Multi-port integer register file with same-edge write-to-read bypass, x0
// hardwired to zero and a per-register busy scoreboard for decode hazard checks.
module rv_rf_mp
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = aw_of(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*AW-1:0]   rd_reg_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_reg_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                rsv_en_i,
  input  logic [AW-1:0]       rsv_reg_i,
  output logic [NREG-1:0]     busy_vec_o
);

  // regs[0] is only ever reset, so it is a constant zero and is trimmed in synthesis.
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] wr_hit;
  logic [XLEN-1:0] wr_val [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;

  logic [NRD-1:0]  byp_hit;
  logic [XLEN-1:0] byp_val   [NRD];
  logic [XLEN-1:0] rd_next   [NRD];
  logic [NRD-1:0]  rd_busy_next;
  logic [XLEN-1:0] rd_data_q [NRD];
  logic [NRD-1:0]  rd_busy_q;

  for (genvar r = 0; r < NREG; r++) begin : g_reg_sel
    rv_rf_wrsel #(.XLEN(XLEN), .NWR(NWR), .AW(AW)) u_sel (
      .idx     (AW'(r)),
      .wr_en   (wr_en_i),
      .wr_reg  (wr_reg_i),
      .wr_data (wr_data_i),
      .hit     (wr_hit[r]),
      .data    (wr_val[r])
    );
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd_byp
    rv_rf_wrsel #(.XLEN(XLEN), .NWR(NWR), .AW(AW)) u_byp (
      .idx     (rd_reg_i[p*AW +: AW]),
      .wr_en   (wr_en_i),
      .wr_reg  (wr_reg_i),
      .wr_data (wr_data_i),
      .hit     (byp_hit[p]),
      .data    (byp_val[p])
    );
    assign rd_data_o[p*XLEN +: XLEN] = rd_data_q[p];
  end

  // A reservation on the same edge as a writeback is the newer one, so set beats clear.
  always_comb begin
    busy_next = busy_q & ~wr_hit;
    if (rsv_en_i && (rsv_reg_i != AW'(REG_ZERO))) begin
      busy_next[rsv_reg_i] = 1'b1;
    end
    busy_next[REG_ZERO] = 1'b0;
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_next[p]      = byp_hit[p] ? byp_val[p] : regs[rd_reg_i[p*AW +: AW]];
      rd_busy_next[p] = busy_next[rd_reg_i[p*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      for (int p = 0; p < NRD; p++) begin
        rd_data_q[p] <= '0;
      end
      rd_busy_q <= '0;
      busy_q    <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
      for (int p = 0; p < NRD; p++) begin
        if (rd_en_i[p]) begin
          rd_data_q[p] <= rd_next[p];
          rd_busy_q[p] <= rd_busy_next[p];
        end
      end
      busy_q <= busy_next;
    end
  end

  assign rd_busy_o  = rd_busy_q;
  assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_rv_rf_mp.sv
// Self-checking bench for rv_rf_mp: directed scenarios followed by random traffic,
// every output compared against an array-based behavioural model.
module tb_rv_rf_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NRD-1:0]      rd_en_i;
  logic [NRD*AW-1:0]   rd_reg_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NWR-1:0]      wr_en_i;
  logic [NWR*AW-1:0]   wr_reg_i;
  logic [NWR*XLEN-1:0] wr_data_i;
  logic                rsv_en_i;
  logic [AW-1:0]       rsv_reg_i;
  logic [NREG-1:0]     busy_vec_o;

  // Stimulus in per-port form; packed onto the DUT buses below.
  logic            rd_en   [NRD];
  logic [AW-1:0]   rd_reg  [NRD];
  logic            wr_en   [NWR];
  logic [AW-1:0]   wr_reg  [NWR];
  logic [XLEN-1:0] wr_data [NWR];

  // Reference model state.
  logic [XLEN-1:0] m_reg  [NREG];
  logic            m_busy [NREG];
  logic [XLEN-1:0] m_rd   [NRD];
  logic            m_rdb  [NRD];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_en_i[p]              = rd_en[p];
      rd_reg_i[p*AW +: AW]    = rd_reg[p];
    end
    for (int w = 0; w < NWR; w++) begin
      wr_en_i[w]              = wr_en[w];
      wr_reg_i[w*AW +: AW]    = wr_reg[w];
      wr_data_i[w*XLEN +: XLEN] = wr_data[w];
    end
  end

  rv_rf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rd_en_i    (rd_en_i),
    .rd_reg_i   (rd_reg_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_reg_i   (wr_reg_i),
    .wr_data_i  (wr_data_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_reg_i  (rsv_reg_i),
    .busy_vec_o (busy_vec_o)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < NRD; p++) begin
      rd_en[p]  = 1'b0;
      rd_reg[p] = '0;
    end
    for (int w = 0; w < NWR; w++) begin
      wr_en[w]   = 1'b0;
      wr_reg[w]  = '0;
      wr_data[w] = '0;
    end
    rsv_en_i  = 1'b0;
    rsv_reg_i = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
    for (int p = 0; p < NRD; p++) begin
      m_rd[p]  = '0;
      m_rdb[p] = 1'b0;
    end
  endtask

  // One clock edge of the architectural behaviour: writes in port order (later
  // port overwrites), writebacks free registers, a reservation then marks busy,
  // and enabled reads observe the post-edge state.
  task automatic model_edge();
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_reg[w] != 0) begin
        m_reg[wr_reg[w]]  = wr_data[w];
        m_busy[wr_reg[w]] = 1'b0;
      end
    end
    if (rsv_en_i && rsv_reg_i != 0) m_busy[rsv_reg_i] = 1'b1;
    for (int p = 0; p < NRD; p++) begin
      if (rd_en[p]) begin
        m_rd[p]  = (rd_reg[p] == 0) ? '0 : m_reg[rd_reg[p]];
        m_rdb[p] = (rd_reg[p] == 0) ? 1'b0 : m_busy[rd_reg[p]];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) model_edge();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [NREG-1:0] exp_busy;
    for (int r = 0; r < NREG; r++) exp_busy[r] = m_busy[r];
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("%s_rd_data%0d", tag, p), rd_data_o[p*XLEN +: XLEN], m_rd[p]);
      chk($sformatf("%s_rd_busy%0d", tag, p), XLEN'(rd_busy_o[p]), XLEN'(m_rdb[p]));
    end
    chk({tag, "_busy_vec"}, XLEN'(busy_vec_o), XLEN'(exp_busy));
  endtask

  initial begin
    idle();
    model_reset();
    rstn = 1'b0;

    // Reset held while writes and a reservation are requested: nothing sticks.
    #2;
    wr_en[0] = 1'b1; wr_reg[0] = 5'd5; wr_data[0] = 64'hFF;
    rsv_en_i = 1'b1; rsv_reg_i = 5'd5;
    step(); step();
    check_all("reset");
    chk("reset_busy_zero", XLEN'(busy_vec_o), '0);
    idle();
    rstn = 1'b1;
    rd_en[0] = 1'b1; rd_reg[0] = 5'd5;
    step();
    check_all("post_reset");
    chk("post_reset_x5", rd_data_o[0 +: XLEN], '0);
    chk("post_reset_busy", XLEN'(busy_vec_o), '0);

    // Basic write then read.
    idle();
    wr_en[0] = 1'b1; wr_reg[0] = 5'd3; wr_data[0] = 64'hDEAD_BEEF;
    step();
    idle();
    rd_en[0] = 1'b1; rd_reg[0] = 5'd3;
    step();
    check_all("basic");
    chk("basic_x3", rd_data_o[0 +: XLEN], 64'hDEAD_BEEF);

    // Same-edge bypass on both read ports.
    idle();
    wr_en[0] = 1'b1; wr_reg[0] = 5'd7; wr_data[0] = 64'h1234;
    rd_en[0] = 1'b1; rd_reg[0] = 5'd7;
    rd_en[1] = 1'b1; rd_reg[1] = 5'd7;
    step();
    check_all("bypass");
    chk("bypass_p0", rd_data_o[0 +: XLEN], 64'h1234);
    chk("bypass_p1", rd_data_o[XLEN +: XLEN], 64'h1234);

    // Disabled read ports hold their last values.
    idle();
    wr_en[0] = 1'b1; wr_reg[0] = 5'd7; wr_data[0] = 64'h5555;
    step();
    check_all("hold");
    chk("hold_p1", rd_data_o[XLEN +: XLEN], 64'h1234);

    // x0 ignores writes and reservations.
    idle();
    wr_en[0] = 1'b1; wr_reg[0] = 5'd0; wr_data[0] = 64'hFFFF;
    rsv_en_i = 1'b1; rsv_reg_i = 5'd0;
    rd_en[0] = 1'b1; rd_reg[0] = 5'd0;
    rd_en[1] = 1'b1; rd_reg[1] = 5'd0;
    step();
    check_all("x0");
    chk("x0_p0", rd_data_o[0 +: XLEN], '0);
    chk("x0_busy0", XLEN'(busy_vec_o[0]), '0);

    // Two write ports on one register: the higher port wins.
    idle();
    wr_en[0] = 1'b1; wr_reg[0] = 5'd9; wr_data[0] = 64'hAA;
    wr_en[1] = 1'b1; wr_reg[1] = 5'd9; wr_data[1] = 64'hBB;
    step();
    idle();
    rd_en[1] = 1'b1; rd_reg[1] = 5'd9;
    step();
    check_all("conflict");
    chk("conflict_x9", rd_data_o[XLEN +: XLEN], 64'hBB);

    // Scoreboard: reserve, re-reserve during writeback, then plain writeback.
    idle();
    rsv_en_i = 1'b1; rsv_reg_i = 5'd4;
    step();
    check_all("sb_rsv");
    chk("sb_rsv_x4", XLEN'(busy_vec_o[4]), 64'd1);
    idle();
    wr_en[0] = 1'b1; wr_reg[0] = 5'd4; wr_data[0] = 64'h44;
    rsv_en_i = 1'b1; rsv_reg_i = 5'd4;
    step();
    check_all("sb_rersv");
    chk("sb_rersv_x4", XLEN'(busy_vec_o[4]), 64'd1);
    idle();
    wr_en[1] = 1'b1; wr_reg[1] = 5'd4; wr_data[1] = 64'h45;
    rd_en[0] = 1'b1; rd_reg[0] = 5'd4;
    step();
    check_all("sb_clear");
    chk("sb_clear_x4", XLEN'(busy_vec_o[4]), '0);
    chk("sb_clear_rdbusy", XLEN'(rd_busy_o[0]), '0);
    chk("sb_clear_data", rd_data_o[0 +: XLEN], 64'h45);

    // Reservation is visible to a read sampled on the same edge.
    idle();
    rsv_en_i = 1'b1; rsv_reg_i = 5'd6;
    rd_en[1] = 1'b1; rd_reg[1] = 5'd6;
    step();
    check_all("rsv_rd");
    chk("rsv_rd_busy", XLEN'(rd_busy_o[1]), 64'd1);

    // Random traffic; small index range half the time to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NRD; p++) begin
        rd_en[p]  = 1'($urandom_range(0, 1));
        rd_reg[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG-1));
      end
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]   = ($urandom_range(0, 2) != 0);
        wr_reg[w]  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG-1));
        wr_data[w] = {$urandom, $urandom};
      end
      rsv_en_i  = 1'($urandom_range(0, 1));
      rsv_reg_i = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG-1));
      step();
      check_all("rand");
    end

    // Asynchronous reset in mid-cycle with a write and reservation pending.
    idle();
    wr_en[0] = 1'b1; wr_reg[0] = 5'd2; wr_data[0] = 64'h77;
    rsv_en_i = 1'b1; rsv_reg_i = 5'd2;
    rd_en[0] = 1'b1; rd_reg[0] = 5'd2;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    step();
    check_all("rst_hold");
    idle();
    rstn = 1'b1;
    rd_en[0] = 1'b1; rd_reg[0] = 5'd2;
    rd_en[1] = 1'b1; rd_reg[1] = 5'd3;
    step();
    check_all("after_rst");
    chk("after_rst_x3", rd_data_o[XLEN +: XLEN], '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
